mant_mult_seq: RTL and testbench
================================

MANT_MULT_SEQ -- requirements
Module: mant_mult_seq

Interface
REQ-001 SHALL have parameter IS_DOUBLE, default 0; 0 selects single-precision widths, 1 selects double-precision widths.
REQ-002 SHALL have parameter MANT_WIDTH, default (IS_DOUBLE ? 53 : 24); significand width including the hidden bit.
REQ-003 SHALL have parameter PROD_WIDTH, default (IS_DOUBLE ? 106 : 48); product width, equal to 2*MANT_WIDTH.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with the following ports.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  operand pair presented.
REQ-008 in_ready  out  1  block can accept an operand pair.
REQ-009 mant_a  in  MANT_WIDTH  multiplicand significand.
REQ-010 mant_b  in  MANT_WIDTH  multiplier significand.
REQ-011 sign_a, sign_b  in  1 each  operand signs.
REQ-012 out_valid  out  1  product available.
REQ-013 out_ready  in  1  downstream rounding stage accepts the product.
REQ-014 product  out  PROD_WIDTH  unsigned mant_a*mant_b, in the exact format the rounding stage consumes.
REQ-015 res_sign  out  1  sign_a XOR sign_b.
REQ-016 busy  out  1  high in CALC or DONE.

Function
REQ-017 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-018 in_ready SHALL equal (state==IDLE); an input handshake is in_valid && in_ready.
REQ-019 On input handshake: latch mant_a and mant_b, clear the accumulator, latch res_sign, load the step counter, and go to CALC.
REQ-020 in_valid asserted in CALC or DONE SHALL be ignored; no latching, no state effect.
REQ-021 Each CALC cycle SHALL consume the low multiplier bit(s), add the selected multiple of the multiplicand to the upper accumulator half, and shift the accumulator right.
REQ-022 The accumulator SHALL be PROD_WIDTH+2 bits internally, so carries out of the upper half are never lost.
REQ-023 Latency is fixed with no early termination on zero operands: out_valid SHALL rise exactly N rising edges after the handshake edge, where N = MANT_WIDTH in the baseline build.
REQ-024 After the final step the FSM SHALL enter DONE, with out_valid=1 and product equal to the exact full-width unsigned product.
REQ-025 In DONE, product and res_sign SHALL stay stable while out_ready=0, for an unbounded stall.
REQ-026 In DONE with out_ready=1: the FSM SHALL return to IDLE next cycle and out_valid SHALL drop; no bypass to CALC.
REQ-027 Throughput SHALL be at most one operation per N+2 cycles.
REQ-028 product SHALL be all-zero whenever out_valid=0.

Reset
REQ-029 rst=1 SHALL force IDLE, in_ready=1, out_valid=0, busy=0, product=0, res_sign=0, and counter and accumulator to 0.
REQ-030 rst asserted in CALC or DONE SHALL abort the operation; no out_valid pulse SHALL follow.
REQ-031 rst SHALL take priority over simultaneous in_valid and out_ready.

Configuration
REQ-032 Macro MANT_MULT_RADIX4_EN defined: each CALC step SHALL consume 2 multiplier bits, adding 0, A, 2A or 3A; 3A is precomputed at the handshake.
REQ-033 With MANT_MULT_RADIX4_EN, N SHALL be ceil(MANT_WIDTH/2), i.e. 12 single / 27 double; for odd MANT_WIDTH the multiplier is zero-extended by one bit.
REQ-034 Macro MANT_MULT_RADIX4_EN undefined: the block SHALL use radix-2, 1 bit per step, N=MANT_WIDTH; product values SHALL be identical in both builds.

Structure
REQ-035 Shared package mult_pkg SHALL hold: the state enum (IDLE/CALC/DONE), the width constants/functions for MANT_WIDTH and PROD_WIDTH per IS_DOUBLE, and a step-count function N(width, radix).
REQ-036 A single sub-module mant_mult_step SHALL implement the combinational add-and-shift of one step; it is radix-selected by the same macro.

Verification
REQ-037 Test 1: 0x800000 x 0x800000, signs 0/1 -> product 48'h400000000000, res_sign=1, out_valid exactly 24 cycles (12 with radix-4) after the handshake.
REQ-038 Test 2: 0xFFFFFF x 0xFFFFFF -> product 48'hFFFFFE000001; with IS_DOUBLE=1, all-ones x all-ones -> 2^106 - 2^54 + 1.
REQ-039 Test 3: out_ready held 0 for 10 cycles in DONE -> product stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-040 Test 4: rst pulsed mid-CALC (step 5) -> IDLE, all outputs 0, no out_valid; a new operation afterwards gives the correct result.
REQ-041 Test 5: second in_valid with different operands during CALC -> ignored; the first product (e.g. 0xC00000 x 0xA00000 = 48'h780000000000) is returned unchanged.
REQ-042 Test 6: mant_b=0 -> product 0, with latency still N.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared state type and sizing helpers for the sequential significand multiplier.
// Build option MANT_MULT_RADIX4_EN selects radix-4 stepping (2 multiplier bits per step).
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef MANT_MULT_RADIX4_EN
  localparam int unsigned RADIX = 4;
`else
  localparam int unsigned RADIX = 2;
`endif

  function automatic int unsigned mant_width(input int unsigned is_double);
    return (is_double != 0) ? 53 : 24;
  endfunction

  function automatic int unsigned prod_width(input int unsigned is_double);
    return 2 * mant_width(is_double);
  endfunction

  function automatic int unsigned radix_bits(input int unsigned radix);
    return (radix == 4) ? 2 : 1;
  endfunction

  function automatic int unsigned step_count(input int unsigned width, input int unsigned radix);
    return (width + radix_bits(radix) - 1) / radix_bits(radix);
  endfunction

endpackage

// File: rtl/mant_mult_step.sv
// Combinational add-and-shift for one multiplier step (radix-2, or radix-4 with
// MANT_MULT_RADIX4_EN defined).
module mant_mult_step
  import mult_pkg::*;
#(
  parameter int unsigned MANT_WIDTH = 24,
  parameter int unsigned PROD_WIDTH = 48,
  parameter int unsigned OFFSET     = 24
) (
  input  logic [PROD_WIDTH+1:0]            i_acc,
  input  logic [MANT_WIDTH-1:0]            i_mcand,
`ifdef MANT_MULT_RADIX4_EN
  input  logic [MANT_WIDTH+1:0]            i_mcand3,
`endif
  input  logic [radix_bits(RADIX)-1:0]     i_mplr_bits,
  output logic [PROD_WIDTH+1:0]            o_acc
);

  localparam int unsigned BITS = radix_bits(RADIX);
  localparam int unsigned AW   = PROD_WIDTH + 2;
  localparam int unsigned SW   = PROD_WIDTH + 3;

  logic [MANT_WIDTH+1:0] w_mult;
  logic [SW-1:0]         w_sum;

  always_comb begin
    w_mult = '0;
`ifdef MANT_MULT_RADIX4_EN
    case (i_mplr_bits)
      2'd1:    w_mult = {2'b00, i_mcand};
      2'd2:    w_mult = {1'b0, i_mcand, 1'b0};
      2'd3:    w_mult = i_mcand3;
      default: w_mult = '0;
    endcase
`else
    if (i_mplr_bits[0]) w_mult = {2'b00, i_mcand};
`endif
  end

  // Sum is one bit wider than the accumulator: with an odd width in radix-4 the
  // pre-shift value can briefly exceed it, and the right shift brings it back in range.
  assign w_sum = {1'b0, i_acc} + (SW'(w_mult) << OFFSET);
  assign o_acc = AW'(w_sum >> BITS);

endmodule

// File: rtl/mant_mult_seq.sv
// Sequential shift-add significand multiplier (IDLE/CALC/DONE) with valid/ready handshakes.
// Define MANT_MULT_RADIX4_EN for radix-4 stepping; default build is radix-2.
module mant_mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned IS_DOUBLE  = 0,
  parameter int unsigned MANT_WIDTH = mant_width(IS_DOUBLE),
  parameter int unsigned PROD_WIDTH = prod_width(IS_DOUBLE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_WIDTH-1:0] mant_a,
  input  logic [MANT_WIDTH-1:0] mant_b,
  input  logic                  sign_a,
  input  logic                  sign_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PROD_WIDTH-1:0] product,
  output logic                  res_sign,
  output logic                  busy
);

  localparam int unsigned BITS  = radix_bits(RADIX);
  localparam int unsigned NSTEP = step_count(MANT_WIDTH, RADIX);
  localparam int unsigned MB    = NSTEP * BITS;
  localparam int unsigned CW    = $clog2(NSTEP + 1);
  localparam int unsigned AW    = PROD_WIDTH + 2;

  state_t                r_state;
  state_t                w_state_next;
  logic [AW-1:0]         r_acc;
  logic [AW-1:0]         w_acc_next;
  logic [MANT_WIDTH-1:0] r_a;
  logic [MB-1:0]         r_b;
  logic [CW-1:0]         r_cnt;
  logic                  r_sign;
  logic                  w_accept;
  logic                  w_last;
`ifdef MANT_MULT_RADIX4_EN
  logic [MANT_WIDTH+1:0] r_a3;
`endif

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = CALC;
      CALC:    if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Multiplier is zero-extended to a whole number of steps (odd widths in radix-4).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
`ifdef MANT_MULT_RADIX4_EN
      r_a3   <= '0;
`endif
    end else if (w_accept) begin
      r_acc  <= '0;
      r_a    <= mant_a;
      r_b    <= MB'(mant_b);
      r_cnt  <= CW'(NSTEP);
      r_sign <= sign_a ^ sign_b;
`ifdef MANT_MULT_RADIX4_EN
      r_a3   <= {2'b00, mant_a} + {1'b0, mant_a, 1'b0};
`endif
    end else if (r_state == CALC) begin
      r_acc <= w_acc_next;
      r_b   <= r_b >> BITS;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  mant_mult_step #(
    .MANT_WIDTH (MANT_WIDTH),
    .PROD_WIDTH (PROD_WIDTH),
    .OFFSET     (MB)
  ) u_step (
    .i_acc       (r_acc),
    .i_mcand     (r_a),
`ifdef MANT_MULT_RADIX4_EN
    .i_mcand3    (r_a3),
`endif
    .i_mplr_bits (r_b[BITS-1:0]),
    .o_acc       (w_acc_next)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == CALC) || (r_state == DONE);
  assign product   = out_valid ? r_acc[PROD_WIDTH-1:0] : '0;
  assign res_sign  = r_sign;

endmodule

// File: tb/tb_mant_mult_seq.sv
// Directed self-checking bench for mant_mult_seq (single- and double-precision instances).
module tb_mant_mult_seq;

`ifdef MANT_MULT_RADIX4_EN
  localparam int NS = 12;
  localparam int ND = 27;
`else
  localparam int NS = 24;
  localparam int ND = 53;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, sign_a, sign_b, out_valid, out_ready, res_sign, busy;
  logic [23:0]  mant_a, mant_b;
  logic [47:0]  product;

  logic         d_in_valid, d_in_ready, d_sign_a, d_sign_b, d_out_valid, d_out_ready, d_res_sign, d_busy;
  logic [52:0]  d_mant_a, d_mant_b;
  logic [105:0] d_product;

  int total = 0;
  int bad   = 0;
  int lat;
  logic [47:0] held;
  logic seen;

  always #5 clk = ~clk;

  mant_mult_seq #(.IS_DOUBLE(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mant_a(mant_a), .mant_b(mant_b), .sign_a(sign_a), .sign_b(sign_b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .res_sign(res_sign), .busy(busy)
  );

  mant_mult_seq #(.IS_DOUBLE(1)) u_dut_dp (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .mant_a(d_mant_a), .mant_b(d_mant_b), .sign_a(d_sign_a), .sign_b(d_sign_b),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .product(d_product),
    .res_sign(d_res_sign), .busy(d_busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [23:0] a, input logic [23:0] b, input logic sa, input logic sb);
    @(negedge clk);
    mant_a = a; mant_b = b; sign_a = sa; sign_b = sb; in_valid = 1'b1;
    chk("hs_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("calc_busy", busy, 1);
  endtask

  task automatic wait_out(input int from, output int n);
    n = from;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_out_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_product", product, 0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mant_a = '0; mant_b = '0; sign_a = 1'b0; sign_b = 1'b0;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_mant_a = '0; d_mant_b = '0;
    d_sign_a = 1'b0; d_sign_b = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    chk("rst_res_sign", res_sign, 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: 0x800000 squared, opposite signs
    start(24'h800000, 24'h800000, 1'b0, 1'b1);
    chk("t1_in_ready_calc", in_ready, 0);
    chk("t1_product_calc", product, 0);
    wait_out(0, lat);
    chk("t1_latency", lat, NS);
    chk("t1_product", product, 48'h400000000000);
    chk("t1_res_sign", res_sign, 1);
    drain();

    // Test 2 + 3: all-ones squared, then a 10-cycle stall in DONE
    start(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1);
    wait_out(0, lat);
    chk("t2_latency", lat, NS);
    chk("t2_product", product, 48'hFFFFFE000001);
    chk("t2_res_sign", res_sign, 0);
    held = product;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t3_stall_product", product, held);
      chk("t3_stall_in_ready", in_ready, 0);
      chk("t3_stall_out_valid", out_valid, 1);
    end
    drain();

    // Test 5: new in_valid during CALC is ignored
    start(24'hC00000, 24'hA00000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; mant_a = 24'h111111; mant_b = 24'h222222; sign_a = 1'b0; sign_b = 1'b1;
      @(posedge clk); #1;
      chk("t5_ignored_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(3, lat);
    chk("t5_latency", lat, NS);
    chk("t5_product", product, 48'h780000000000);
    chk("t5_res_sign", res_sign, 0);
    drain();

    // Test 4: reset at CALC step 5 aborts, then a fresh operation is correct
    start(24'h123456, 24'h654321, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_rst_in_ready", in_ready, 1);
    chk("t4_rst_out_valid", out_valid, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_product", product, 0);
    chk("t4_rst_res_sign", res_sign, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    seen = 1'b0;
    repeat (NS + 6) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("t4_no_out_valid", seen, 0);
    chk("t4_idle_after_abort", in_ready, 1);
    start(24'h800001, 24'h800001, 1'b0, 1'b0);
    wait_out(0, lat);
    chk("t4_new_latency", lat, NS);
    chk("t4_new_product", product, 48'h400001000001);
    drain();
    start(24'hABCDEF, 24'h000002, 1'b1, 1'b0);
    wait_out(0, lat);
    chk("t4_b2_product", product, 48'h000001579BDE);
    chk("t4_b2_res_sign", res_sign, 1);
    drain();

    // Test 6: zero multiplier, latency unchanged
    start(24'hFFFFFF, 24'h000000, 1'b0, 1'b0);
    wait_out(0, lat);
    chk("t6_latency", lat, NS);
    chk("t6_product", product, 0);
    chk("t6_out_valid", out_valid, 1);
    drain();

    // Double precision: all-ones squared = 2^106 - 2^54 + 1
    @(negedge clk);
    d_mant_a = {53{1'b1}}; d_mant_b = {53{1'b1}}; d_sign_a = 1'b1; d_sign_b = 1'b0;
    d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    lat = 0;
    while (d_out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("dp_latency", lat, ND);
    chk("dp_product", d_product, {52'hFFFFFFFFFFFFF, 53'd0, 1'b1});
    chk("dp_res_sign", d_res_sign, 1);
    @(negedge clk);
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("dp_drain_in_ready", d_in_ready, 1);
    chk("dp_drain_product", d_product, 0);
    d_out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
